alu_control: RTL and testbench
==============================

// Module: alu_control
// PURPOSE
//  - Decodes the main-decoder ALU class (i_alu_ctl) plus instruction fields
//    (funct3, opcode bit 5, funct7 bit 5) into a 3-bit ALU operation code.
//  - Sits between the control unit and the ALU of the RV32I datapath.
//  - Output is registered: one clock of latency.
// PARAMETERS
//  - none (all widths fixed by the ISA encoding below)
// PORTS
//  - i_clk      in   1  clock, rising-edge active
//  - i_rst_n    in   1  reset, asynchronous, active-low
//  - i_alu_ctl  in   2  ALU class: 00 = add, 01 = sub, 10 = funct3 decode, 11 = reserved
//  - i_f3       in   3  instruction funct3
//  - i_op5      in   1  opcode bit 5 (1 = R-type, 0 = I-type)
//  - i_f7_5     in   1  funct7 bit 5
//  - o_alu_op   out  3  registered ALU operation code
//  - o_illegal  out  1  registered illegal-combination flag (ALU_CTRL_ILLEGAL_DET_EN only)
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - o_alu_op codes:
//    - 000 ADD, 001 SUB, 010 AND, 011 OR
//    - 100 XOR, 101 SLT, 110 SLL, 111 SRL
//  - Reset: o_alu_op = 000 and o_illegal = 0, asserted immediately on i_rst_n low.
//  - Decode is purely combinational; its result is captured into o_alu_op on
//    every rising i_clk while i_rst_n is high. There is no enable or handshake.
//  - Latency: a change on any input appears on o_alu_op after the next rising edge.
//  - i_alu_ctl = 00: ADD; f3, op5 and f7_5 are ignored.
//  - i_alu_ctl = 01: SUB; f3, op5 and f7_5 are ignored.
//  - i_alu_ctl = 10, decode on i_f3:
//    - 000: SUB if (i_op5 & i_f7_5), else ADD (I-type addi always gives ADD)
//    - 001: SLL
//    - 010: SLT
//    - 011: unsupported (sltu) -> ADD
//    - 100: XOR
//    - 101: SRL (f7_5 ignored; arithmetic shift is not supported)
//    - 110: OR
//    - 111: AND
//  - i_alu_ctl = 11: reserved -> ADD.
//  - Default for every unsupported case is ADD (000). The output never holds a stale value.
//  - Reset deasserted mid-cycle: the first capture happens on the next rising edge.
// CONFIGURATION
//  - ALU_CTRL_ILLEGAL_DET_EN defined:
//    - o_illegal port exists and is registered alongside o_alu_op.
//    - o_illegal = 1 for i_alu_ctl = 11, or for i_alu_ctl = 10 with f3 = 011;
//      otherwise 0.
//  - ALU_CTRL_ILLEGAL_DET_EN undefined:
//    - o_illegal port is absent.
//    - The o_alu_op decode is identical in both builds.
// TESTING
//  - Hold i_rst_n = 0 with arbitrary inputs -> o_alu_op = 000 asynchronously;
//    o_illegal = 0.
//  - alu_ctl = 00, f3 = 111, op5 = 1 -> ADD (000); then alu_ctl = 01 -> SUB (001),
//    each one edge later.
//  - alu_ctl = 10, op5 = 1: f3 = 111 -> AND (010); 110 -> OR (011); 010 -> SLT (101).
//  - alu_ctl = 10, f3 = 000: op5 = 1 with f7_5 = 1 -> SUB (001);
//    op5 = 1 with f7_5 = 0 -> ADD (000); op5 = 0 with f7_5 = 1 -> ADD (000).
//  - alu_ctl = 10, op5 = 0: f3 = 001 -> SLL (110); 100 -> XOR (100); 101 -> SRL (111).
//  - alu_ctl = 11, or alu_ctl = 10 with f3 = 011 -> ADD (000);
//    o_illegal = 1 when ALU_CTRL_ILLEGAL_DET_EN is defined.

Source files
------------

// File: rtl/alu_control_if.sv
// rtl/alu_control_if.sv - decode-field bundle between control unit and alu_control
// ALU_CTRL_ILLEGAL_DET_EN adds the o_illegal flag to the bundle.
interface alu_control_if;
  logic [1:0] i_alu_ctl;
  logic [2:0] i_f3;
  logic       i_op5;
  logic       i_f7_5;
  logic [2:0] o_alu_op;
`ifdef ALU_CTRL_ILLEGAL_DET_EN
  logic       o_illegal;

  modport master (
    output i_alu_ctl, i_f3, i_op5, i_f7_5,
    input  o_alu_op, o_illegal
  );

  modport slave (
    input  i_alu_ctl, i_f3, i_op5, i_f7_5,
    output o_alu_op, o_illegal
  );
`else
  modport master (
    output i_alu_ctl, i_f3, i_op5, i_f7_5,
    input  o_alu_op
  );

  modport slave (
    input  i_alu_ctl, i_f3, i_op5, i_f7_5,
    output o_alu_op
  );
`endif
endinterface

// File: rtl/alu_control.sv
// rtl/alu_control.sv - RV32I ALU-class/funct decode to a registered 3-bit ALU op
// ALU_CTRL_ILLEGAL_DET_EN enables the registered o_illegal flag.
module alu_control (
  input  logic          i_clk,
  input  logic          i_rst_n,
  alu_control_if.slave  bus
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  localparam logic [1:0] CTL_ADD    = 2'b00;
  localparam logic [1:0] CTL_SUB    = 2'b01;
  localparam logic [1:0] CTL_FUNCT  = 2'b10;

  logic [2:0] alu_op_d;
  logic       illegal_d;

  // Every unsupported combination falls back to ADD so the ALU never sees a stale op.
  always_comb begin
    alu_op_d  = OP_ADD;
    illegal_d = 1'b0;
    case (bus.i_alu_ctl)
      CTL_ADD: alu_op_d = OP_ADD;
      CTL_SUB: alu_op_d = OP_SUB;
      CTL_FUNCT: begin
        case (bus.i_f3)
          3'b000: alu_op_d = (bus.i_op5 && bus.i_f7_5) ? OP_SUB : OP_ADD;
          3'b001: alu_op_d = OP_SLL;
          3'b010: alu_op_d = OP_SLT;
          3'b011: begin
            alu_op_d  = OP_ADD;
            illegal_d = 1'b1;
          end
          3'b100: alu_op_d = OP_XOR;
          3'b101: alu_op_d = OP_SRL;
          3'b110: alu_op_d = OP_OR;
          3'b111: alu_op_d = OP_AND;
          default: alu_op_d = OP_ADD;
        endcase
      end
      default: begin
        alu_op_d  = OP_ADD;
        illegal_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_alu_op <= OP_ADD;
    end else begin
      bus.o_alu_op <= alu_op_d;
    end
  end

`ifdef ALU_CTRL_ILLEGAL_DET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_illegal <= 1'b0;
    end else begin
      bus.o_illegal <= illegal_d;
    end
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal_d;
`endif

endmodule

// File: tb/tb_alu_control.sv
// tb/tb_alu_control.sv - table-driven check of alu_control decode, latency and reset
// Checks o_illegal as well when ALU_CTRL_ILLEGAL_DET_EN is defined.
module tb_alu_control;

  logic clk;
  logic rst_n;
  alu_control_if bus ();

  alu_control dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [1:0] ctl;
    logic [2:0] f3;
    logic       op5;
    logic       f7;
    logic [2:0] op;
    logic       ill;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_op(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: o_alu_op got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check_ill(input string name, input logic exp);
`ifdef ALU_CTRL_ILLEGAL_DET_EN
    n_checks++;
    if (bus.o_illegal !== exp) begin
      n_fail++;
      $display("FAIL %s: o_illegal got %b expected %b", name, bus.o_illegal, exp);
    end
`else
    if (exp === 1'bx) $display("unexpected x in %s", name);
`endif
  endtask

  task automatic drive(input logic [1:0] ctl, input logic [2:0] f3, input logic op5, input logic f7);
    bus.i_alu_ctl = ctl;
    bus.i_f3      = f3;
    bus.i_op5     = op5;
    bus.i_f7_5    = f7;
  endtask

  initial begin
    logic [2:0] prev;

    vecs[0]  = '{"add_ignores_fields", 2'b00, 3'b111, 1'b1, 1'b1, 3'b000, 1'b0};
    vecs[1]  = '{"sub_ignores_fields", 2'b01, 3'b111, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[2]  = '{"sub_zero_fields",    2'b01, 3'b000, 1'b0, 1'b0, 3'b001, 1'b0};
    vecs[3]  = '{"and_r",              2'b10, 3'b111, 1'b1, 1'b0, 3'b010, 1'b0};
    vecs[4]  = '{"or_r",               2'b10, 3'b110, 1'b1, 1'b0, 3'b011, 1'b0};
    vecs[5]  = '{"slt_r",              2'b10, 3'b010, 1'b1, 1'b0, 3'b101, 1'b0};
    vecs[6]  = '{"sub_r",              2'b10, 3'b000, 1'b1, 1'b1, 3'b001, 1'b0};
    vecs[7]  = '{"add_r",              2'b10, 3'b000, 1'b1, 1'b0, 3'b000, 1'b0};
    vecs[8]  = '{"addi_f7_set",        2'b10, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0};
    vecs[9]  = '{"sll_i",              2'b10, 3'b001, 1'b0, 1'b0, 3'b110, 1'b0};
    vecs[10] = '{"xor_i",              2'b10, 3'b100, 1'b0, 1'b0, 3'b100, 1'b0};
    vecs[11] = '{"srl_i",              2'b10, 3'b101, 1'b0, 1'b0, 3'b111, 1'b0};
    vecs[12] = '{"srl_f7_ignored",     2'b10, 3'b101, 1'b1, 1'b1, 3'b111, 1'b0};
    vecs[13] = '{"sltu_unsupported",   2'b10, 3'b011, 1'b1, 1'b0, 3'b000, 1'b1};
    vecs[14] = '{"reserved_ctl_a",     2'b11, 3'b000, 1'b1, 1'b1, 3'b000, 1'b1};
    vecs[15] = '{"reserved_ctl_b",     2'b11, 3'b101, 1'b0, 1'b0, 3'b000, 1'b1};
    vecs[16] = '{"add_f3_011_legal",   2'b00, 3'b011, 1'b1, 1'b0, 3'b000, 1'b0};

    // Reset held with inputs that would otherwise decode to SRL.
    rst_n = 1'b0;
    drive(2'b10, 3'b101, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check_op("reset_hold", bus.o_alu_op, 3'b000);
    check_ill("reset_hold", 1'b0);

    // Release mid-cycle: nothing captured until the next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_op("release_before_edge", bus.o_alu_op, 3'b000);
    @(posedge clk);
    #1;
    check_op("first_capture", bus.o_alu_op, 3'b111);
    prev = 3'b111;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].ctl, vecs[i].f3, vecs[i].op5, vecs[i].f7);
      #1;
      check_op({vecs[i].name, "_latency"}, bus.o_alu_op, prev);
      @(posedge clk);
      #1;
      check_op(vecs[i].name, bus.o_alu_op, vecs[i].op);
      check_ill(vecs[i].name, vecs[i].ill);
      prev = vecs[i].op;
    end

    // Asynchronous reset away from the clock edge clears a non-zero op and flag.
    drive(2'b10, 3'b101, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_op("pre_async_srl", bus.o_alu_op, 3'b111);
    drive(2'b11, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_ill("pre_async_illegal", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_op("async_reset_op", bus.o_alu_op, 3'b000);
    check_ill("async_reset_ill", 1'b0);
    drive(2'b01, 3'b000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_op("reset_blocks_capture", bus.o_alu_op, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_op("post_reset_sub", bus.o_alu_op, 3'b001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
